// File: rtl/xnor_pkg.sv
// Shared types and sizing for the binary (XNOR) 3x3 convolution datapath.
package xnor_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StFill1,
    StFill2,
    StFull
  } fill_state_e;

  localparam int unsigned KernelSize    = 3;
  localparam int unsigned RowWidth      = 16;
  localparam int unsigned NumCols       = RowWidth - KernelSize + 1;
  localparam logic [3:0]  DefaultThresh = 4'd5;

endpackage

// File: rtl/xnor_popcount9.sv
// 3x3 window XNOR against the kernel, followed by a popcount of the 9 match bits.
module xnor_popcount9 (
  input  logic [8:0] win_i,
  input  logic [8:0] wgt_i,
  output logic [3:0] cnt_o
);

  logic [8:0] match;

  assign match = ~(win_i ^ wgt_i);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < 9; i++) begin
      cnt_o = cnt_o + {3'b000, match[i]};
    end
  end

endmodule

// File: rtl/xnor_conv_datapath.sv
// Three-row sliding window with a binary 3x3 convolution producing one packed output row.
// Define XNOR_CONV_THRESH_EN to add a run-time threshold port; otherwise majority (5) is used.
module xnor_conv_datapath
  import xnor_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        weight_load,
  input  logic [15:0] weight_mdr,
  input  logic        row_valid,
  input  logic [15:0] input_mdr,
  input  logic [15:0] dim,
  input  logic        conv_valid,
`ifdef XNOR_CONV_THRESH_EN
  input  logic [3:0]  thresh,
`endif
  output logic [15:0] output_mdr,
  output logic        output_valid,
  output logic        underrun
);

  fill_state_e state_q, state_d;
  logic [15:0] row0_q, row0_d, row1_q, row1_d, row2_q, row2_d;
  logic [8:0]  wgt_q, wgt_d;
  logic [15:0] out_q, out_d;
  logic        valid_q, valid_d;
  logic        underrun_q, underrun_d;

  logic [3:0]  thr;
  logic [3:0]  cnt [NumCols];
  logic [15:0] conv_bits;
  logic        dim_ok;
  logic        unused_wgt_hi;

`ifdef XNOR_CONV_THRESH_EN
  assign thr = thresh;
`else
  assign thr = DefaultThresh;
`endif

  assign unused_wgt_hi = ^weight_mdr[15:9];

  for (genvar c = 0; c < NumCols; c++) begin : g_col
    logic [8:0] win;
    // Bit 3*r+k of the window is row r, column c+k, matching the kernel word layout.
    assign win = {row2_q[c+2:c], row1_q[c+2:c], row0_q[c+2:c]};

    xnor_popcount9 u_pop (
      .win_i (win),
      .wgt_i (wgt_q),
      .cnt_o (cnt[c])
    );
  end

  assign dim_ok = (dim >= 16'd3) && (dim <= 16'(RowWidth));

  always_comb begin
    conv_bits = '0;
    for (int c = 0; c < NumCols; c++) begin
      conv_bits[c] = dim_ok && (dim > 16'(c + 2)) && (cnt[c] >= thr);
    end
  end

  always_comb begin
    state_d    = state_q;
    row0_d     = row0_q;
    row1_d     = row1_q;
    row2_d     = row2_q;
    wgt_d      = wgt_q;
    out_d      = out_q;
    valid_d    = 1'b0;
    underrun_d = underrun_q;

    if (weight_load) begin
      wgt_d = weight_mdr[8:0];
    end

    // Convolution sees the pre-edge window and weights; shifts land at the same edge.
    if (conv_valid) begin
      if (state_q == StFull) begin
        valid_d = 1'b1;
        out_d   = conv_bits;
      end else begin
        underrun_d = 1'b1;
      end
    end

    if (flush) begin
      state_d = StEmpty;
      row0_d  = '0;
      row1_d  = '0;
      row2_d  = '0;
    end else if (row_valid) begin
      row0_d = row1_q;
      row1_d = row2_q;
      row2_d = input_mdr;
      unique case (state_q)
        StEmpty: state_d = StFill1;
        StFill1: state_d = StFill2;
        StFill2: state_d = StFull;
        StFull:  state_d = StFull;
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StEmpty;
      row0_q     <= '0;
      row1_q     <= '0;
      row2_q     <= '0;
      wgt_q      <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row0_q     <= row0_d;
      row1_q     <= row1_d;
      row2_q     <= row2_d;
      wgt_q      <= wgt_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign output_mdr   = out_q;
  assign output_valid = valid_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_xnor_conv_datapath.sv
// Directed bench for xnor_conv_datapath: vector table plus multi-cycle corner sequences.
module tb_xnor_conv_datapath;

  logic        clk = 1'b0;
  logic        reset, flush, weight_load, row_valid, conv_valid;
  logic [15:0] weight_mdr, input_mdr, dim;
  logic [15:0] output_mdr;
  logic        output_valid, underrun;
`ifdef XNOR_CONV_THRESH_EN
  logic [3:0]  thresh;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  xnor_conv_datapath dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .weight_load  (weight_load),
    .weight_mdr   (weight_mdr),
    .row_valid    (row_valid),
    .input_mdr    (input_mdr),
    .dim          (dim),
    .conv_valid   (conv_valid),
`ifdef XNOR_CONV_THRESH_EN
    .thresh       (thresh),
`endif
    .output_mdr   (output_mdr),
    .output_valid (output_valid),
    .underrun     (underrun)
  );

  typedef struct {
    string       name;
    logic [15:0] w;
    logic [15:0] r0;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] dim;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_w(input logic [15:0] w);
    weight_load = 1'b1;
    weight_mdr  = w;
    tick();
    weight_load = 1'b0;
  endtask

  task automatic push_row(input logic [15:0] r);
    row_valid = 1'b1;
    input_mdr = r;
    tick();
    row_valid = 1'b0;
  endtask

  task automatic conv();
    conv_valid = 1'b1;
    tick();
    conv_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; weight_load = 1'b0; row_valid = 1'b0; conv_valid = 1'b0;
    weight_mdr = '0; input_mdr = '0; dim = 16'd16;
`ifdef XNOR_CONV_THRESH_EN
    thresh = 4'd5;
`endif

    vecs[0]  = '{"ones_w_ones_rows",  16'h01FF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd16, 16'h3FFF};
    vecs[1]  = '{"zero_w_ones_rows",  16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd16, 16'h0000};
    vecs[2]  = '{"zero_w_zero_rows",  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd16, 16'h3FFF};
    vecs[3]  = '{"dim10",             16'h01FF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd10, 16'h00FF};
    vecs[4]  = '{"dim2",              16'h01FF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd2,  16'h0000};
    vecs[5]  = '{"dim17",             16'h01FF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd17, 16'h0000};
    vecs[6]  = '{"dim3",              16'h01FF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd3,  16'h0001};
    vecs[7]  = '{"low_nibble_rows",   16'h01FF, 16'h000F, 16'h000F, 16'h000F, 16'd16, 16'h0007};
    vecs[8]  = '{"alt_bits_rows",     16'h01FF, 16'h5555, 16'h5555, 16'h5555, 16'd16, 16'h1555};
    vecs[9]  = '{"row_order",         16'h01C0, 16'hFFFF, 16'h0000, 16'h0000, 16'd16, 16'h0000};
    vecs[10] = '{"col_offset",        16'h0049, 16'h0004, 16'h0004, 16'h0004, 16'd16, 16'h3FFC};

    tick();
    do_reset();
    check("reset_output_mdr", output_mdr, 16'h0000);
    check("reset_output_valid", {15'd0, output_valid}, 16'h0000);
    check("reset_underrun", {15'd0, underrun}, 16'h0000);

    foreach (vecs[i]) begin
      do_reset();
      dim = vecs[i].dim;
      load_w(vecs[i].w);
      push_row(vecs[i].r0);
      push_row(vecs[i].r1);
      push_row(vecs[i].r2);
      conv();
      check({vecs[i].name, "_valid"}, {15'd0, output_valid}, 16'h0001);
      check(vecs[i].name, output_mdr, vecs[i].exp);
    end

    // Valid is a single pulse and the data holds afterwards.
    tick();
    check("hold_valid_low", {15'd0, output_valid}, 16'h0000);
    check("hold_output_mdr", output_mdr, 16'h3FFC);

    // Underrun after two rows, sticky through flush, cleared by reset.
    do_reset();
    dim = 16'd16;
    load_w(16'h01FF);
    push_row(16'hFFFF);
    push_row(16'hFFFF);
    conv();
    check("underrun_no_valid", {15'd0, output_valid}, 16'h0000);
    check("underrun_set", {15'd0, underrun}, 16'h0001);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("underrun_after_flush", {15'd0, underrun}, 16'h0001);
    do_reset();
    check("underrun_cleared", {15'd0, underrun}, 16'h0000);

    // Concurrent conv + row shift uses the pre-edge window.
    load_w(16'h01C0);
    push_row(16'h0000);
    push_row(16'h0000);
    push_row(16'hFFFF);
    conv_valid = 1'b1;
    row_valid  = 1'b1;
    input_mdr  = 16'h0000;
    tick();
    conv_valid = 1'b0;
    row_valid  = 1'b0;
    check("shift_conv_old_window", output_mdr, 16'h3FFF);
    conv();
    check("shift_conv_new_window", output_mdr, 16'h0000);

    // Weight load concurrent with conv uses the old weights.
    do_reset();
    load_w(16'h01FF);
    push_row(16'hFFFF);
    push_row(16'hFFFF);
    push_row(16'hFFFF);
    conv_valid  = 1'b1;
    weight_load = 1'b1;
    weight_mdr  = 16'h0000;
    tick();
    conv_valid  = 1'b0;
    weight_load = 1'b0;
    check("wload_old_weights", output_mdr, 16'h3FFF);
    conv();
    check("wload_new_weights", output_mdr, 16'h0000);

    // Flush beats row_valid; a FULL conv in the flush cycle still completes.
    load_w(16'h01FF);
    flush      = 1'b1;
    row_valid  = 1'b1;
    conv_valid = 1'b1;
    input_mdr  = 16'hFFFF;
    tick();
    flush      = 1'b0;
    row_valid  = 1'b0;
    conv_valid = 1'b0;
    check("flush_conv_valid", {15'd0, output_valid}, 16'h0001);
    check("flush_conv_data", output_mdr, 16'h3FFF);
    push_row(16'hFFFF);
    push_row(16'hFFFF);
    conv();
    check("flush_two_rows_no_valid", {15'd0, output_valid}, 16'h0000);
    push_row(16'hFFFF);
    conv();
    check("flush_refill_valid", {15'd0, output_valid}, 16'h0001);

    // Reset overrides concurrent activity.
    reset      = 1'b1;
    conv_valid = 1'b1;
    row_valid  = 1'b1;
    tick();
    reset      = 1'b0;
    conv_valid = 1'b0;
    row_valid  = 1'b0;
    check("reset_override_valid", {15'd0, output_valid}, 16'h0000);
    check("reset_override_mdr", output_mdr, 16'h0000);

`ifdef XNOR_CONV_THRESH_EN
    load_w(16'h01FF);
    push_row(16'h0000);
    push_row(16'h0000);
    push_row(16'h0000);
    thresh = 4'd0;
    conv();
    check("thresh0", output_mdr, 16'h3FFF);
    thresh = 4'd10;
    load_w(16'h0000);
    conv();
    check("thresh10", output_mdr, 16'h0000);
    thresh = 4'd5;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xnor_conv_datapath.md
XNOR_CONV_DATAPATH -- requirements
Module: xnor_conv_datapath

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port flush, input, 1, clears the row window and fill state at the next edge.
REQ-004 SHALL have port weight_load, input, 1, captures weight_mdr[8:0] at the next edge.
REQ-005 SHALL have port weight_mdr, input, 16, kernel word; bit 3*r+k is the row r (0 = oldest), column offset k weight.
REQ-006 SHALL have port row_valid, input, 1, shifts input_mdr into the window.
REQ-007 SHALL have port input_mdr, input, 16, one image row; bit i is column i.
REQ-008 SHALL have port dim, input, 16, image width; only values 3..16 are legal.
REQ-009 SHALL have port conv_valid, input, 1, requests one output row from the current window.
REQ-010 SHALL have port output_mdr, output, 16, packed output row; bit c is output column c.
REQ-011 SHALL have port output_valid, output, 1, marks output_mdr valid for one cycle.
REQ-012 SHALL have port underrun, output, 1, sticky flag for a conv_valid seen while the window is not FULL.

Function
REQ-013 SHALL keep three row registers row0 (oldest), row1 and row2 (newest); row_valid shifts row0<=row1, row1<=row2, row2<=input_mdr.
REQ-014 SHALL run the fill FSM EMPTY->FILL1->FILL2->FULL, advancing one state per row_valid and staying in FULL on further row_valid.
REQ-015 SHALL compute output bit c for c in 0..dim-3 as popcount(~(window[r][c+k] ^ w[3r+k])) over r,k in 0..2, compared >= threshold.
REQ-016 SHALL force output bits c >= dim-2 to 0; if dim < 3 or dim > 16, every output bit SHALL be 0.
REQ-017 SHALL use the window state from before the edge when conv_valid and row_valid are both high in the same cycle; the shift also occurs at that edge.
REQ-018 SHALL register the result with latency 1: output_valid follows a conv_valid accepted in FULL by one cycle and is otherwise 0.
REQ-019 SHALL ignore conv_valid when not FULL (output_valid stays 0) and set underrun to 1, which holds until reset.
REQ-020 SHALL give flush priority over row_valid in the same cycle: FSM goes to EMPTY and the rows to 0, while a concurrent FULL conv_valid still produces its output.
REQ-021 SHALL apply weight_load at the edge; a conv_valid in the same cycle uses the old weights.
REQ-022 SHALL hold output_mdr between valid pulses.

Reset
REQ-023 SHALL on reset clear the rows, weights, output_mdr, output_valid and underrun to 0 and put the FSM in EMPTY; reset overrides every other input.

Configuration
REQ-024 SHALL, with XNOR_CONV_THRESH_EN defined, add input port thresh[3:0] and compare popcount >= thresh, where thresh = 0 gives all-ones in valid columns and thresh > 9 gives all zeros.
REQ-025 SHALL, without XNOR_CONV_THRESH_EN, have no thresh port and use a fixed threshold of 5 (majority).

Structure
REQ-026 SHALL place the fill-state enum, the default threshold (5), the kernel size (3) and the row width (16) in shared package xnor_pkg.
REQ-027 SHALL instantiate sub-module xnor_popcount9 (9-bit XNOR plus popcount, 4-bit result) once per output column, 14 instances.

Verification
REQ-028 SHALL cover: reset, weights 0x1FF, three rows 0xFFFF, dim 16, conv_valid -> next cycle output_valid=1, output_mdr=0x3FFF.
REQ-029 SHALL cover: weights 0x000, rows 0xFFFF x3, dim 16 -> output_mdr=0x0000; rows 0x0000 x3 -> 0x3FFF.
REQ-030 SHALL cover: dim 10, weights 0x1FF, rows 0xFFFF -> output_mdr=0x00FF; dim 2 -> 0x0000.
REQ-031 SHALL cover: conv_valid after two rows -> no output_valid, underrun=1, still 1 after flush; cleared only by reset.
REQ-032 SHALL cover: in FULL, rows A,B,C then conv_valid+row_valid(D) together -> output computed from A,B,C; the next conv_valid uses B,C,D.
REQ-033 SHALL cover: flush and row_valid in the same cycle -> FSM EMPTY, three more rows needed before output; with XNOR_CONV_THRESH_EN, thresh=0 and dim 16 -> 0x3FFF.
